// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter and data_mem.
package dmem_arb_pkg;

   localparam int unsigned BE_WIDTH  = 4;
   localparam int unsigned LT_WIDTH  = 3;
   localparam int unsigned CNT_WIDTH = 8;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      LOCK1 = 2'd1,
      YIELD = 2'd2
   } arb_state_t;

   // funct3 load encodings understood by data_mem
   typedef enum logic [LT_WIDTH-1:0] {
      LT_LB  = 3'b000,
      LT_LH  = 3'b001,
      LT_LW  = 3'b010,
      LT_LBU = 3'b100,
      LT_LHU = 3'b101
   } load_type_t;

   // Control fields of one memory request
   typedef struct packed {
      logic                we;
      logic [BE_WIDTH-1:0] be;
      logic [LT_WIDTH-1:0] load_type;
   } req_ctrl_t;

endpackage

// File: rtl/dmem_arb_port_ret.sv
// Registered read-return stage for one arbiter port.
module dmem_arb_port_ret #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  gnt,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rvalid,
   output logic [DATA_WIDTH-1:0] rdata
);

   // Capture load data on a load grant; rdata holds between loads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= gnt & ~we;
         if (gnt && !we) begin
            rdata <= rd_data;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for data_mem: port 0 fixed priority, port 1 starvation-protected with lock bursts.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned LOCK_MAX     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  p0_req,
   input  logic                  p0_we,
   input  logic [BE_WIDTH-1:0]   p0_be,
   input  logic [LT_WIDTH-1:0]   p0_load_type,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   output logic                  p0_gnt,
   output logic                  p0_rvalid,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   input  logic                  p1_req,
   input  logic                  p1_we,
   input  logic [BE_WIDTH-1:0]   p1_be,
   input  logic [LT_WIDTH-1:0]   p1_load_type,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   input  logic                  p1_lock,
   output logic                  p1_gnt,
   output logic                  p1_rvalid,
   output logic [DATA_WIDTH-1:0] p1_rdata,
   output logic                  mem_wr_en,
   output logic                  mem_rd_en,
   output logic [BE_WIDTH-1:0]   mem_write_byte_enable,
   output logic [LT_WIDTH-1:0]   mem_load_type,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data
);

   arb_state_t           state;
   logic [CNT_WIDTH-1:0] wait_cnt;
   logic [CNT_WIDTH-1:0] lock_cnt;
   logic [CNT_WIDTH-1:0] lock_inc;
   logic                 starved;
   req_ctrl_t            p0_ctrl;
   req_ctrl_t            p1_ctrl;
   req_ctrl_t            sel_ctrl;

   assign starved  = (wait_cnt == CNT_WIDTH'(STARVE_LIMIT));
   assign lock_inc = lock_cnt + CNT_WIDTH'(1);
   assign p0_ctrl  = '{we: p0_we, be: p0_be, load_type: p0_load_type};
   assign p1_ctrl  = '{we: p1_we, be: p1_be, load_type: p1_load_type};

   // Grant decision; nothing is granted while reset is asserted
   always_comb begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
      if (rst_n) begin
         case (state)
            ARB: begin
               if (p1_req && (!p0_req || starved)) begin
                  p1_gnt = 1'b1;
               end else if (p0_req) begin
                  p0_gnt = 1'b1;
               end
            end
            LOCK1:   p1_gnt = p1_req;
            YIELD:   p0_gnt = p0_req;
            default: ;
         endcase
      end
   end

   // Drive the winner's fields onto data_mem; all zero when idle
   always_comb begin
      sel_ctrl    = '0;
      mem_addr    = '0;
      mem_wr_data = '0;
      if (p1_gnt) begin
         sel_ctrl    = p1_ctrl;
         mem_addr    = p1_addr;
         mem_wr_data = p1_wdata;
      end else if (p0_gnt) begin
         sel_ctrl    = p0_ctrl;
         mem_addr    = p0_addr;
         mem_wr_data = p0_wdata;
      end
      mem_wr_en             = (p0_gnt | p1_gnt) & sel_ctrl.we;
      mem_rd_en             = (p0_gnt | p1_gnt) & ~sel_ctrl.we;
      mem_write_byte_enable = sel_ctrl.be;
      mem_load_type         = sel_ctrl.load_type;
   end

   // Arbitration state, starvation counter and lock-length counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ARB;
         wait_cnt <= '0;
         lock_cnt <= '0;
      end else begin
         if (p1_req && !p1_gnt) begin
            if (!starved) begin
               wait_cnt <= wait_cnt + CNT_WIDTH'(1);
            end
         end else begin
            wait_cnt <= '0;
         end

         case (state)
            ARB: begin
               if (p1_gnt && p1_lock) begin
                  lock_cnt <= CNT_WIDTH'(1);
                  state    <= (LOCK_MAX == 1) ? YIELD : LOCK1;
               end
            end
            LOCK1: begin
               if (!p1_req) begin
                  lock_cnt <= '0;
                  state    <= ARB;
               end else if (lock_inc == CNT_WIDTH'(LOCK_MAX)) begin
                  lock_cnt <= lock_inc;
                  state    <= YIELD;
               end else if (!p1_lock) begin
                  lock_cnt <= '0;
                  state    <= ARB;
               end else begin
                  lock_cnt <= lock_inc;
               end
            end
            YIELD: begin
               lock_cnt <= '0;
               state    <= ARB;
            end
            default: begin
               lock_cnt <= '0;
               state    <= ARB;
            end
         endcase
      end
   end

   dmem_arb_port_ret #(.DATA_WIDTH(DATA_WIDTH)) u_ret0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .gnt     (p0_gnt),
      .we      (p0_we),
      .rd_data (mem_rd_data),
      .rvalid  (p0_rvalid),
      .rdata   (p0_rdata)
   );

   dmem_arb_port_ret #(.DATA_WIDTH(DATA_WIDTH)) u_ret1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .gnt     (p1_gnt),
      .we      (p1_we),
      .rd_data (mem_rd_data),
      .rvalid  (p1_rvalid),
      .rdata   (p1_rdata)
   );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a small behavioural data_mem.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        p0_req, p0_we, p0_gnt, p0_rvalid;
   logic [3:0]  p0_be;
   logic [2:0]  p0_load_type;
   logic [31:0] p0_addr, p0_wdata, p0_rdata;
   logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_lock;
   logic [3:0]  p1_be;
   logic [2:0]  p1_load_type;
   logic [31:0] p1_addr, p1_wdata, p1_rdata;
   logic        mem_wr_en, mem_rd_en;
   logic [3:0]  mem_write_byte_enable;
   logic [2:0]  mem_load_type;
   logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

   int n_cmp = 0;
   int n_bad = 0;

   dmem_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(8), .LOCK_MAX(16)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_load_type(p0_load_type),
      .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt),
      .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_load_type(p1_load_type),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_lock(p1_lock), .p1_gnt(p1_gnt),
      .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
      .mem_write_byte_enable(mem_write_byte_enable), .mem_load_type(mem_load_type),
      .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural data_mem: 256 bytes, combinational read, synchronous byte-enabled write
   logic [31:0] mem [64];
   logic [31:0] mword, msh;

   always_comb begin
      mword       = mem[mem_addr[7:2]];
      msh         = mword >> {mem_addr[1:0], 3'b000};
      mem_rd_data = '0;
      if (mem_addr < 32'd256) begin
         case (mem_load_type)
            LT_LB:   mem_rd_data = {{24{msh[7]}}, msh[7:0]};
            LT_LH:   mem_rd_data = {{16{msh[15]}}, msh[15:0]};
            LT_LW:   mem_rd_data = mword;
            LT_LBU:  mem_rd_data = {24'd0, msh[7:0]};
            LT_LHU:  mem_rd_data = {16'd0, msh[15:0]};
            default: mem_rd_data = '0;
         endcase
      end
   end

   always @(posedge clk) begin
      if (mem_wr_en && mem_addr < 32'd256) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_write_byte_enable[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      p0_req = 0; p0_we = 0; p0_be = 0; p0_load_type = 0; p0_addr = 0; p0_wdata = 0;
      p1_req = 0; p1_we = 0; p1_be = 0; p1_load_type = 0; p1_addr = 0; p1_wdata = 0;
      p1_lock = 0;
   endtask

   typedef struct {
      logic        r0, w0; logic [3:0] be0; logic [2:0] lt0; logic [31:0] a0, d0;
      logic        r1, w1; logic [3:0] be1; logic [2:0] lt1; logic [31:0] a1, d1; logic lk;
      logic        eg0, eg1, ewr, erd; logic [31:0] eaddr;
      logic        erv0, erv1; logic [31:0] erd0, erd1;
   } vec_t;

   vec_t vecs [14];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      //             r0 w0 be0   lt0    a0          d0            r1 w1 be1   lt1    a1     d1          lk  g0 g1 wr rd addr        rv0 rv1 rd0           rd1
      vecs[0]  = '{1, 1, 4'hF, LT_LW, 32'h10,    32'hDEADBEEF, 0, 0, 4'h0, 3'd0,  32'h0, 32'h0,      0,  1, 0, 1, 0, 32'h10,    0, 0, 32'h0,        32'h0};
      vecs[1]  = '{1, 0, 4'h0, LT_LW, 32'h10,    32'h0,        0, 0, 4'h0, 3'd0,  32'h0, 32'h0,      0,  1, 0, 0, 1, 32'h10,    0, 0, 32'h0,        32'h0};
      vecs[2]  = '{0, 0, 4'h0, 3'd0,  32'h0,     32'h0,        0, 0, 4'h0, 3'd0,  32'h0, 32'h0,      0,  0, 0, 0, 0, 32'h0,     1, 0, 32'hDEADBEEF, 32'h0};
      vecs[3]  = '{0, 0, 4'h0, 3'd0,  32'h0,     32'h0,        1, 1, 4'h2, 3'd0,  32'h21, 32'h8000,  0,  0, 1, 1, 0, 32'h21,    0, 0, 32'hDEADBEEF, 32'h0};
      vecs[4]  = '{1, 0, 4'h0, LT_LB, 32'h21,    32'h0,        0, 0, 4'h0, 3'd0,  32'h0, 32'h0,      0,  1, 0, 0, 1, 32'h21,    0, 0, 32'hDEADBEEF, 32'h0};
      vecs[5]  = '{1, 0, 4'h0, LT_LBU, 32'h21,   32'h0,        0, 0, 4'h0, 3'd0,  32'h0, 32'h0,      0,  1, 0, 0, 1, 32'h21,    1, 0, 32'hFFFFFF80, 32'h0};
      vecs[6]  = '{0, 0, 4'h0, 3'd0,  32'h0,     32'h0,        1, 0, 4'h0, LT_LHU, 32'h20, 32'h0,    0,  0, 1, 0, 1, 32'h20,    1, 0, 32'h00000080, 32'h0};
      vecs[7]  = '{1, 0, 4'h0, LT_LW, 32'h10,    32'h0,        1, 0, 4'h0, LT_LW, 32'h20, 32'h0,     0,  1, 0, 0, 1, 32'h10,    0, 1, 32'h00000080, 32'h8000};
      vecs[8]  = '{0, 0, 4'h0, 3'd0,  32'h0,     32'h0,        0, 0, 4'h0, 3'd0,  32'h0, 32'h0,      0,  0, 0, 0, 0, 32'h0,     1, 0, 32'hDEADBEEF, 32'h8000};
      vecs[9]  = '{1, 0, 4'h0, LT_LW, 32'h1000,  32'h0,        0, 0, 4'h0, 3'd0,  32'h0, 32'h0,      0,  1, 0, 0, 1, 32'h1000,  0, 0, 32'hDEADBEEF, 32'h8000};
      vecs[10] = '{0, 0, 4'h0, 3'd0,  32'h0,     32'h0,        0, 0, 4'h0, 3'd0,  32'h0, 32'h0,      0,  0, 0, 0, 0, 32'h0,     1, 0, 32'h0,        32'h8000};
      vecs[11] = '{1, 1, 4'hF, LT_LW, 32'h1000,  32'h12345678, 0, 0, 4'h0, 3'd0,  32'h0, 32'h0,      0,  1, 0, 1, 0, 32'h1000,  0, 0, 32'h0,        32'h8000};
      vecs[12] = '{1, 0, 4'h0, LT_LW, 32'h1000,  32'h0,        0, 0, 4'h0, 3'd0,  32'h0, 32'h0,      0,  1, 0, 0, 1, 32'h1000,  0, 0, 32'h0,        32'h8000};
      vecs[13] = '{0, 0, 4'h0, 3'd0,  32'h0,     32'h0,        0, 0, 4'h0, 3'd0,  32'h0, 32'h0,      0,  0, 0, 0, 0, 32'h0,     1, 0, 32'h0,        32'h8000};

      for (int i = 0; i < 64; i++) mem[i] = '0;

      // Reset: a request during reset must not be granted
      drive_idle();
      rst_n = 1'b0;
      p0_req = 1'b1;
      #1;
      check("rst_p0_gnt", 32'(p0_gnt), 32'd0);
      check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
      check("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
      check("rst_p1_rdata", p1_rdata, 32'd0);
      repeat (2) @(negedge clk);
      drive_idle();
      rst_n = 1'b1;

      // Table-driven single-cycle vectors
      for (int i = 0; i < 14; i++) begin
         p0_req = vecs[i].r0; p0_we = vecs[i].w0; p0_be = vecs[i].be0; p0_load_type = vecs[i].lt0;
         p0_addr = vecs[i].a0; p0_wdata = vecs[i].d0;
         p1_req = vecs[i].r1; p1_we = vecs[i].w1; p1_be = vecs[i].be1; p1_load_type = vecs[i].lt1;
         p1_addr = vecs[i].a1; p1_wdata = vecs[i].d1; p1_lock = vecs[i].lk;
         #1;
         check($sformatf("v%0d_gnt0", i), 32'(p0_gnt), 32'(vecs[i].eg0));
         check($sformatf("v%0d_gnt1", i), 32'(p1_gnt), 32'(vecs[i].eg1));
         check($sformatf("v%0d_wr_en", i), 32'(mem_wr_en), 32'(vecs[i].ewr));
         check($sformatf("v%0d_rd_en", i), 32'(mem_rd_en), 32'(vecs[i].erd));
         check($sformatf("v%0d_addr", i), mem_addr, vecs[i].eaddr);
         check($sformatf("v%0d_rvalid0", i), 32'(p0_rvalid), 32'(vecs[i].erv0));
         check($sformatf("v%0d_rvalid1", i), 32'(p1_rvalid), 32'(vecs[i].erv1));
         check($sformatf("v%0d_rdata0", i), p0_rdata, vecs[i].erd0);
         check($sformatf("v%0d_rdata1", i), p1_rdata, vecs[i].erd1);
         @(negedge clk);
      end
      drive_idle();

      // Starvation: both ports request every cycle -> 8 port-0 grants then 1 port-1 grant
      for (int c = 0; c < 18; c++) begin
         p0_req = 1; p0_we = 0; p0_load_type = LT_LW; p0_addr = 32'h10;
         p1_req = 1; p1_we = 0; p1_load_type = LT_LW; p1_addr = 32'h20; p1_lock = 0;
         #1;
         check($sformatf("starve%0d_gnt0", c), 32'(p0_gnt), 32'((c % 9) != 8));
         check($sformatf("starve%0d_gnt1", c), 32'(p1_gnt), 32'((c % 9) == 8));
         @(negedge clk);
      end
      drive_idle();
      @(negedge clk);

      // Locked 20-beat port-1 burst against one pending port-0 load
      begin
         int  beats;
         logic p0_done, eg0, eg1;
         beats = 0;
         p0_done = 0;
         for (int c = 0; c < 22; c++) begin
            p1_req = (beats < 20); p1_we = 1; p1_be = 4'hF; p1_lock = 1;
            p1_addr = 32'h40 + 32'(beats * 4); p1_wdata = 32'(beats);
            p0_req = (c >= 1) && !p0_done; p0_we = 0; p0_load_type = LT_LW; p0_addr = 32'h10;
            eg1 = (c < 16) || (c >= 17 && c <= 20);
            eg0 = (c == 16);
            #1;
            check($sformatf("lock%0d_gnt0", c), 32'(p0_gnt), 32'(eg0));
            check($sformatf("lock%0d_gnt1", c), 32'(p1_gnt), 32'(eg1));
            if (c == 17) begin
               check("lock_yield_rvalid0", 32'(p0_rvalid), 32'd1);
               check("lock_yield_rdata0", p0_rdata, 32'hDEADBEEF);
            end
            if (eg1) beats++;
            if (eg0) p0_done = 1;
            @(negedge clk);
         end
      end
      drive_idle();
      @(negedge clk);
      check("burst_last_beat_written", mem[(32'h40 + 19*4) >> 2], 32'd19);

      // Reset while locked with a load return pending
      p1_req = 1; p1_we = 0; p1_load_type = LT_LW; p1_addr = 32'h20; p1_lock = 1;
      #1;
      check("rlock_gnt1", 32'(p1_gnt), 32'd1);
      @(negedge clk);
      p0_req = 1; p0_we = 0; p0_load_type = LT_LW; p0_addr = 32'h10;
      #1;
      check("rlock_locked_gnt0", 32'(p0_gnt), 32'd0);
      check("rlock_pending_rvalid1", 32'(p1_rvalid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rlock_rst_gnt0", 32'(p0_gnt), 32'd0);
      check("rlock_rst_gnt1", 32'(p1_gnt), 32'd0);
      check("rlock_rst_rvalid1", 32'(p1_rvalid), 32'd0);
      check("rlock_rst_rdata1", p1_rdata, 32'd0);
      check("rlock_rst_rd_en", 32'(mem_rd_en), 32'd0);
      check("rlock_rst_addr", mem_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rlock_post_gnt0", 32'(p0_gnt), 32'd1);
      check("rlock_post_gnt1", 32'(p1_gnt), 32'd0);
      @(negedge clk);
      drive_idle();
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-ported `data_mem` between the CPU load/store unit (port 0) and a DMA/debug master (port 1). It grants at most one access per cycle, drives `data_mem`'s combinational-read/synchronous-write port, and returns registered read data one cycle after grant. Port 0 has fixed priority. Port 1 is protected by a starvation counter and may lock the memory for short bursts.

## Interface
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width
- `STARVE_LIMIT`, 8, consecutive denied cycles after which port 1 wins one arbitration (1..255)
- `LOCK_MAX`, 16, maximum consecutive locked port-1 grants (1..255)
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `pN_req`  in  1  port N (N=0,1) request; held stable with all request fields until `pN_gnt`
- `pN_we`  in  1  1 = store, 0 = load
- `pN_be`  in  4  store byte enables
- `pN_load_type`  in  3  funct3 load encoding (LB/LH/LW/LBU/LHU)
- `pN_addr`  in  ADDR_WIDTH  byte address
- `pN_wdata`  in  DATA_WIDTH  store data
- `pN_gnt`  out  1  combinational grant; access is performed this cycle
- `pN_rvalid`  out  1  registered; read data valid, one cycle after a load grant
- `pN_rdata`  out  DATA_WIDTH  registered load data
- `p1_lock`  in  1  port 1 requests to keep ownership for following beats
- `mem_wr_en`, `mem_rd_en`  out  1 each  to `data_mem`
- `mem_write_byte_enable`  out  4; `mem_load_type` out 3; `mem_addr` out ADDR_WIDTH; `mem_wr_data` out DATA_WIDTH
- `mem_rd_data`  in  DATA_WIDTH  `data_mem` combinational read data

## Operation
- FSM states: ARB (normal arbitration), LOCK1 (port 1 owns memory), YIELD (one cycle reserved for port 0 after lock expiry).
- ARB: winner = port 1 if `p1_req` and (`!p0_req` or `wait_cnt == STARVE_LIMIT`); else port 0 if `p0_req`. A port-1 grant with `p1_lock=1` moves to LOCK1, with `lock_cnt` set to 1.
- LOCK1: port 1 is granted whenever `p1_req`; port 0 is never granted. `lock_cnt` increments per port-1 grant. The state exits to ARB when `p1_req=0` or `p1_lock=0`. It goes to YIELD when a grant makes `lock_cnt == LOCK_MAX`.
- YIELD: port 0 is granted if `p0_req`, and port 1 is denied. The state always returns to ARB next cycle.
- `wait_cnt` (8 bit): increments, saturating at `STARVE_LIMIT`, on cycles with `p1_req && !p1_gnt`. It clears on `p1_gnt` or `!p1_req`.
- Memory drive: the winner's fields are muxed onto `mem_*`. `mem_wr_en = gnt & we` and `mem_rd_en = gnt & !we`. With no grant, all `mem_*` outputs are 0.
- Read return: on a load grant, `mem_rd_data` is captured into that port's `pN_rdata` and `pN_rvalid` pulses the next cycle. `pN_rdata` holds its value otherwise. Stores produce no `rvalid`.
- Simultaneous `p0_req`/`p1_req` in ARB without starvation: port 0 wins and `wait_cnt` increments.
- Out-of-range addresses are passed through unchanged; `data_mem` returns 0 and drops the write.

## Timing
- Grant latency: 0 cycles (combinational from req and state). Store commits at the rising edge ending the grant cycle. Load data appears on `pN_rdata`/`pN_rvalid` 1 cycle after grant.
- Throughput: 1 access per cycle total.
- Worst-case port-1 wait: `STARVE_LIMIT` cycles. Worst-case port-0 wait: `LOCK_MAX` cycles.
- Reset values: state ARB; `wait_cnt`, `lock_cnt`, `pN_rvalid` and `pN_rdata` all 0. `pN_gnt` and `mem_*` are 0 while `rst_n=0`.
- Reset mid-operation: an in-flight `rvalid` is dropped and lock state is abandoned. The first cycle after release behaves as ARB.
- A request deasserted before grant is legal and is not performed.

## Structure
- Shared package/header `dmem_arb_pkg`: FSM state encoding (ARB=2'd0, LOCK1=2'd1, YIELD=2'd2) and load_type constants shared with `data_mem`.
- One natural sub-module, `dmem_arb_port_ret`, instantiated per port: a registered `rvalid`/`rdata` return stage.
- Top level holds the FSM, counters and request mux.

## Test plan
- Port 0 only: SW of 0xDEADBEEF to 0x10, then LW from 0x10 → `p0_gnt` asserted in the same cycle for each access; the next cycle has `p0_rvalid=1` and `p0_rdata=0xDEADBEEF`.
- Both ports requesting continuously, `STARVE_LIMIT=8` → port 0 is granted for 8 cycles, then port 1 for 1 cycle; the pattern repeats.
- Port 1 locked burst of 20 beats with `LOCK_MAX=16` and port 0 requesting → 16 port-1 grants, then 1 YIELD port-0 grant, then port 1 resumes.
- Mixed widths: port 1 SB 0x80 at 0x21, then port 0 LB from 0x21 → `p0_rdata=0xFFFFFF80`; LBU from 0x21 → 0x00000080.
- Assert `rst_n=0` in LOCK1 with an `rvalid` pending → all outputs are 0 immediately. After release, simultaneous requests grant port 0.
